// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared funct3 encodings, bridge states and access-rule helpers
package rv_mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  // Only the five load/store widths the core issues are legal funct3 values.
  function automatic logic op_defined(input logic [2:0] op);
    return (op == MEM_B) || (op == MEM_H) || (op == MEM_W) ||
           (op == MEM_BU) || (op == MEM_HU);
  endfunction

  // Words need 4-byte alignment, halves 2-byte; bytes are always aligned.
  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] a);
    return ((op == MEM_W) && (a != 2'b00)) ||
           (((op == MEM_H) || (op == MEM_HU)) && a[0]);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for stores and alignment/extension for loads
module lsu_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  sel,
  output logic [31:0] dat,
  output logic [31:0] rdata
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Store direction: op[1:0] picks the width; undefined encodings fall into word.
  always_comb begin
    sel = 4'b1111;
    dat = wdata;
    case (op[1:0])
      2'b00: begin
        sel = 4'b0001 << a;
        dat = {4{wdata[7:0]}};
      end
      2'b01: begin
        sel = a[1] ? 4'b1100 : 4'b0011;
        dat = {2{wdata[15:0]}};
      end
      default: begin
        sel = 4'b1111;
        dat = wdata;
      end
    endcase
  end

  // Load direction: pick the addressed lane, then sign- or zero-extend by op[2].
  always_comb begin
    byte_lane = raw[7:0];
    half_lane = a[1] ? raw[31:16] : raw[15:0];
    case (a)
      2'd0:    byte_lane = raw[7:0];
      2'd1:    byte_lane = raw[15:8];
      2'd2:    byte_lane = raw[23:16];
      default: byte_lane = raw[31:24];
    endcase
    rdata = raw;
    case (op[1:0])
      2'b00:   rdata = op[2] ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   rdata = op[2] ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/core_wb_dmem_bridge.sv
// rtl/core_wb_dmem_bridge.sv - MEM-stage load/store to single classic Wishbone cycle bridge
module core_wb_dmem_bridge
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        stall_pipl,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o
);

  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  bridge_state_t state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          req;
  logic [2:0]    lane_op;
  logic [1:0]    lane_a;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_dat;
  logic [31:0]   lane_rdata;
  logic [CNT_W:0] cnt_inc;

  assign req = mem_read_mem | mem_write_mem;

  // Lane helper sees the live request while idle and the latched access afterwards.
  assign lane_op = (state_q == IDLE) ? mem_op_mem : op_q;
  assign lane_a  = (state_q == IDLE) ? mem_addr_mem[1:0] : a_q;

  lsu_lane_align u_lane (
    .op    (lane_op),
    .a     (lane_a),
    .wdata (mem_wdata_mem),
    .raw   (wb_dat_i),
    .sel   (lane_sel),
    .dat   (lane_dat),
    .rdata (lane_rdata)
  );

  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state and register updates for the IDLE -> BUS -> DONE access sequence.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    op_d    = op_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (op_misaligned(mem_op_mem, mem_addr_mem[1:0])) begin
            state_d = DONE;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else begin
            state_d = BUS;
            adr_d   = {mem_addr_mem[31:2], 2'b00};
            sel_d   = lane_sel;
            dat_d   = lane_dat;
            we_d    = mem_write_mem;
            op_d    = mem_op_mem;
            a_d     = mem_addr_mem[1:0];
            cyc_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      BUS: begin
        cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
        if (wb_err_i) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (wb_ack_i) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          if (!op_defined(op_q)) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (!we_q) begin
            rdata_d = lane_rdata;
          end
        end else if (cnt_inc >= TO_LIM) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any cycle in flight silently.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      op_q    <= 3'h0;
      a_q     <= 2'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      op_q    <= op_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign stall_pipl    = ((state_q == IDLE) && req) || (state_q == BUS);
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign mem_rdata_mem = rdata_q;
  assign bus_err_o     = err_q;

endmodule

// File: tb/tb_core_wb_dmem_bridge.sv
// tb/tb_core_wb_dmem_bridge.sv - randomized self-checking bench for core_wb_dmem_bridge
module tb_core_wb_dmem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr_mem, mem_wdata_mem, mem_rdata_mem;
  logic        mem_write_mem, mem_read_mem;
  logic [2:0]  mem_op_mem;
  logic        stall_pipl;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, bus_err_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  core_wb_dmem_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
    .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
    .mem_op_mem(mem_op_mem), .mem_rdata_mem(mem_rdata_mem),
    .stall_pipl(stall_pipl),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_err_o(bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_defined(input int op);
    return op == 0 || op == 1 || op == 2 || op == 4 || op == 5;
  endfunction

  function automatic bit ref_misaligned(input int op, input int a);
    if (op == 2) return a != 0;
    if (op == 1 || op == 5) return (a % 2) != 0;
    return 0;
  endfunction

  function automatic int ref_width(input int op);
    if (op == 0 || op == 4) return 1;
    if (op == 1 || op == 5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_sel(input int op, input int a);
    int w = ref_width(op);
    if (w == 1) return 32'(1 << a);
    if (w == 2) return 32'(3 << (a / 2 * 2));
    return 32'hF;
  endfunction

  function automatic logic [31:0] ref_wdat(input int op, input logic [31:0] wd);
    int w = ref_width(op);
    if (w == 1) return (wd & 32'hFF) * 32'h01010101;
    if (w == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input int op, input int a, input logic [31:0] raw);
    logic [31:0] b, h;
    b = (raw >> (8 * a)) & 32'hFF;
    h = (raw >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      0: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      4: return b;
      1: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      5: return h;
      default: return raw;
    endcase
  endfunction

  // mode: 0 = ack after waits, 1 = err in bus cycle errcyc, 2 = never respond
  task automatic access(input string tag, input bit wr, input int op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input int mode,
                        input int errcyc, input logic [31:0] raw);
    int a, exp_busn, st, busn, stbn;
    bit mis, exp_err, done;
    logic [31:0] exp_rdata, cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;
    a = int'(addr[1:0]);
    mis = ref_misaligned(op, a);
    exp_busn = mis ? 0 : (mode == 0 ? waits + 1 : (mode == 1 ? errcyc : TO));
    exp_err = mis || mode != 0 || !ref_defined(op);
    exp_rdata = exp_err ? 32'h0 : (wr ? last_rdata : ref_load(op, a, raw));
    last_rdata = exp_rdata;
    cap_adr = 'x; cap_dat = 'x; cap_sel = 'x; cap_we = 'x;

    @(posedge clk); #1;
    mem_addr_mem = addr; mem_wdata_mem = wdata; mem_op_mem = 3'(op);
    mem_write_mem = wr; mem_read_mem = ~wr;
    st = 0; busn = 0; stbn = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall_pipl) st++;
      if (wb_stb_o) stbn++;
      if (wb_cyc_o) begin
        busn++;
        if (busn == 1) begin
          cap_adr = wb_adr_o; cap_sel = wb_sel_o; cap_we = wb_we_o; cap_dat = wb_dat_o;
        end
        wb_ack_i = (mode == 0) && (busn == waits + 1);
        wb_err_i = (mode == 1) && (busn == errcyc);
        wb_dat_i = raw;
      end else begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
      end
      if (!stall_pipl) done = 1;
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".stall"}, st, 1 + exp_busn);
    check({tag, ".cyc"}, busn, exp_busn);
    check({tag, ".stb"}, stbn, exp_busn);
    if (!mis) begin
      check({tag, ".adr"}, cap_adr, {addr[31:2], 2'b00});
      check({tag, ".sel"}, 32'(cap_sel), ref_sel(op, a));
      check({tag, ".we"}, 32'(cap_we), 32'(wr));
      if (wr) check({tag, ".dat"}, cap_dat, ref_wdat(op, wdata));
    end
    check({tag, ".rdata"}, mem_rdata_mem, exp_rdata);
    check({tag, ".err"}, 32'(bus_err_o), 32'(exp_err));
    mem_write_mem = 1'b0; mem_read_mem = 1'b0;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check({tag, ".noreissue"}, 32'(wb_cyc_o), 32'd0);
    check({tag, ".errpulse"}, 32'(bus_err_o), 32'd0);
    check({tag, ".idle_stall"}, 32'(stall_pipl), 32'd0);
    check({tag, ".rhold"}, mem_rdata_mem, exp_rdata);
  endtask

  initial begin
    reset_n = 1'b0;
    mem_addr_mem = 0; mem_wdata_mem = 0; mem_write_mem = 0; mem_read_mem = 0; mem_op_mem = 0;
    wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.cyc", 32'(wb_cyc_o), 0);
    check("rst.stb", 32'(wb_stb_o), 0);
    check("rst.we", 32'(wb_we_o), 0);
    check("rst.sel", 32'(wb_sel_o), 0);
    check("rst.adr", wb_adr_o, 0);
    check("rst.dat", wb_dat_o, 0);
    check("rst.rdata", mem_rdata_mem, 0);
    check("rst.err", 32'(bus_err_o), 0);
    check("rst.stall", 32'(stall_pipl), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    access("lw100", 0, 2, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF);
    access("sb203", 1, 0, 32'h203, 32'h123456A5, 2, 0, 0, 32'h0);
    access("lb3",   0, 0, 32'h103, 0, 1, 0, 0, 32'h80FF7F01);
    access("lbu3",  0, 4, 32'h103, 0, 0, 0, 0, 32'h80FF7F01);
    access("lh2",   0, 1, 32'h102, 0, 0, 0, 0, 32'h80FF7F01);
    access("lhu0",  0, 5, 32'h100, 0, 2, 0, 0, 32'h80FF7F01);
    access("lhmis", 0, 1, 32'h101, 0, 0, 0, 0, 32'h80FF7F01);
    access("tmo",   0, 2, 32'h400, 0, 0, 2, 0, 32'h11111111);
    access("lw_ok", 0, 2, 32'h404, 0, 0, 0, 0, 32'h22222222);
    access("berr",  0, 2, 32'h400, 0, 0, 1, 2, 32'h33333333);
    access("undef", 0, 3, 32'h40,  0, 1, 0, 0, 32'h44444444);
    access("shhi",  1, 1, 32'h502, 32'hCAFEBEEF, 0, 0, 0, 32'h0);

    // reset during a bus cycle drops cyc/stb silently
    @(posedge clk); #1;
    mem_addr_mem = 32'h300; mem_op_mem = 3'd2; mem_read_mem = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mrst.inbus", 32'(wb_cyc_o), 1);
    @(posedge clk); #1 reset_n = 1'b0; mem_read_mem = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst.cyc", 32'(wb_cyc_o), 0);
    check("mrst.stb", 32'(wb_stb_o), 0);
    check("mrst.stall", 32'(stall_pipl), 0);
    check("mrst.err", 32'(bus_err_o), 0);
    check("mrst.rdata", mem_rdata_mem, 0);
    last_rdata = 32'h0;
    #1 reset_n = 1'b1;
    access("postrst", 0, 2, 32'h300, 0, 0, 0, 0, 32'h5A5A1234);

    for (int i = 0; i < 60; i++) begin
      bit wr;
      int op, r, mode, waits, ec;
      wr = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0) op = (i % 3 == 0) ? 3 : ((i % 3 == 1) ? 6 : 7);
      else if (wr) op = int'($urandom_range(0, 2));
      else begin
        r = int'($urandom_range(0, 4));
        op = (r == 3) ? 4 : ((r == 4) ? 5 : r);
      end
      r = int'($urandom_range(0, 9));
      mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      waits = int'($urandom_range(0, 2));
      ec = int'($urandom_range(1, TO));
      access($sformatf("rnd%0d", i), wr, op, $urandom, $urandom, waits, mode, ec, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
